// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer family.
//   state_t  : sequencer state encoding (also exported on the debug port)
//   clog2    : ceil(log2(value)), usable in constant expressions
//   max2     : larger of two integers, for sizing shared counters
// -----------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronised output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always written with non-blocking assignments so
  // that every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// Reset sequencer for a PLL and the clock domains it feeds. Pulses the PLL
// reset, waits for a stable lock (with timeout and bounded retries), then
// releases the downstream channel resets one at a time.
//
// Parameters
//   N_CH         : number of downstream channel resets (1..8)
//   RST_PULSE    : pll_rst pulse length in clkin1 cycles (>=2)
//   LOCK_STABLE  : cycles lock must stay high before releasing channels
//   LOCK_TIMEOUT : cycles allowed waiting for lock before a retry
//   STAGGER      : cycles between successive channel releases (>=1)
//   MAX_RETRY    : timeouts tolerated before entering FAIL (0..15)
//
// Ports
//   clkin1    in   sole clock
//   rst       in   asynchronous active-high reset
//   pll_lock  in   raw PLL lock (asynchronous)
//   soft_rst  in   synchronous one-cycle restart request
//   pll_rst   out  reset to the PLL primitive
//   ch_rst    out  per-channel resets, bit 0 released first
//   all_ready out  high only in RUN
//   fail      out  high only in FAIL
//   retry_cnt out  timeouts since the last rst/soft_rst
//   loss_cnt  out  saturating count of lock losses after release began
//   state     out  current state encoding (debug)
// -----------------------------------------------------------------------------
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic            clkin1,
  input  logic            rst,
  input  logic            pll_lock,
  input  logic            soft_rst,
  output logic            pll_rst,
  output logic [N_CH-1:0] ch_rst,
  output logic            all_ready,
  output logic            fail,
  output logic [3:0]      retry_cnt,
  output logic [7:0]      loss_cnt,
  output logic [2:0]      state
);

  // One counter serves every timed state, so it is sized for the longest.
  localparam int CNT_MAX = max2(max2(RST_PULSE, LOCK_TIMEOUT),
                                max2(LOCK_STABLE, STAGGER * N_CH));
  localparam int CNT_W   = clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(STAGGER * N_CH - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  logic lock_s;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic [N_CH-1:0]  ch_nxt;
  logic [N_CH-1:0]  rel_mask;

  sync_2ff u_lock_sync (
    .clk (clkin1),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Channel k is released on the edge that ends RELEASE cycle STAGGER*(k+1)-1,
  // i.e. STAGGER*(k+1) edges after RELEASE was entered.
  always_comb begin
    rel_mask = '0;
    for (int k = 0; k < N_CH; k++) begin
      rel_mask[k] = (cnt == CNT_W'(STAGGER * (k + 1) - 1));
    end
  end

  // Next-state decision. Priority: soft_rst, then lock loss, then timeout,
  // then normal advance (rst is handled asynchronously in the register block).
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    ch_nxt    = ch_rst;

    if (soft_rst) begin
      st_nxt    = ST_PLL_RST;
      cnt_nxt   = '0;
      retry_nxt = '0;
      ch_nxt    = '1;
    end else begin
      case (st)
        ST_PLL_RST: begin
          ch_nxt = '1;
          if (cnt == RST_LAST) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = '0;
          end
        end

        ST_WAIT_LOCK: begin
          ch_nxt = '1;
          if (lock_s) begin
            st_nxt  = ST_STABLE;
            cnt_nxt = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nxt = '0;
            if (retry_cnt == RETRY_LIMIT) begin
              st_nxt = ST_FAIL;
            end else begin
              st_nxt    = ST_PLL_RST;
              retry_nxt = retry_cnt + 4'd1;
            end
          end
        end

        ST_STABLE: begin
          ch_nxt = '1;
          if (!lock_s) begin
            // Any glitch restarts both the stability window and the timeout.
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STABLE_LAST) begin
            st_nxt  = ST_RELEASE;
            cnt_nxt = '0;
          end
        end

        ST_RELEASE: begin
          if (!lock_s) begin
            st_nxt  = ST_PLL_RST;
            cnt_nxt = '0;
            ch_nxt  = '1;
            if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
          end else begin
            // Released bits only ever go low here; they come back via '1 above.
            ch_nxt = ch_rst & ~rel_mask;
            if (cnt == RELEASE_LAST) begin
              st_nxt  = ST_RUN;
              cnt_nxt = '0;
            end
          end
        end

        ST_RUN: begin
          cnt_nxt = cnt;
          if (!lock_s) begin
            st_nxt  = ST_PLL_RST;
            cnt_nxt = '0;
            ch_nxt  = '1;
            if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
          end
        end

        ST_FAIL: begin
          cnt_nxt = cnt;
          ch_nxt  = '1;
        end

        default: begin
          st_nxt  = ST_PLL_RST;
          cnt_nxt = '0;
          ch_nxt  = '1;
        end
      endcase
    end
  end

  // All outputs are registered from the next state, so they change on the same
  // edge as the state and never see pll_lock or soft_rst combinationally.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      st        <= ST_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      ch_rst    <= '1;
      all_ready <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (st_nxt == ST_PLL_RST) || (st_nxt == ST_FAIL);
      ch_rst    <= ch_nxt;
      all_ready <= (st_nxt == ST_RUN);
      fail      <= (st_nxt == ST_FAIL);
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
// Directed bench for pll_rst_seq with N_CH=3, RST_PULSE=4, LOCK_STABLE=8,
// LOCK_TIMEOUT=32, STAGGER=2, MAX_RETRY=2. Inputs change and outputs are
// sampled on the falling edge; nK below means the falling edge K cycles after
// the falling edge on which rst was released.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;
  import pll_seq_pkg::*;

  logic       clkin1;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst;
  logic       pll_rst;
  logic [2:0] ch_rst;
  logic       all_ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  pll_rst_seq #(
    .N_CH        (3),
    .RST_PULSE   (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .STAGGER     (2),
    .MAX_RETRY   (2)
  ) dut (
    .clkin1   (clkin1),
    .rst      (rst),
    .pll_lock (pll_lock),
    .soft_rst (soft_rst),
    .pll_rst  (pll_rst),
    .ch_rst   (ch_rst),
    .all_ready(all_ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .state    (state)
  );

  initial clkin1 = 1'b0;
  always #5 clkin1 = ~clkin1;

  task automatic tick(input int n);
    repeat (n) @(negedge clkin1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input state_t exp);
    check(tag, 32'(state), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    tick(2);

    // Reset values while rst is held.
    check_st("rst_state", ST_PLL_RST);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_ch_rst", 32'(ch_rst), 32'h7);
    check("rst_all_ready", 32'(all_ready), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_loss", 32'(loss_cnt), 32'd0);

    // ---- Nominal bring-up: lock at n10, held --------------------------------
    rst = 1'b0;                                         // n0
    tick(1); check("s1_pll_rst_n1", 32'(pll_rst), 32'd1);
    tick(2); check("s1_pll_rst_n3", 32'(pll_rst), 32'd1);
    tick(1); check("s1_pll_rst_n4", 32'(pll_rst), 32'd0);
             check_st("s1_wait_n4", ST_WAIT_LOCK);
    tick(6); pll_lock = 1'b1;                           // n10
    tick(2); check_st("s1_wait_n12", ST_WAIT_LOCK);     // lock_s just rose
    tick(1); check_st("s1_stable_n13", ST_STABLE);
    tick(7); check_st("s1_stable_n20", ST_STABLE);
    tick(1); check_st("s1_release_n21", ST_RELEASE);
             check("s1_ch_n21", 32'(ch_rst), 32'h7);
    tick(1); check("s1_ch_n22", 32'(ch_rst), 32'h7);
    tick(1); check("s1_ch_n23", 32'(ch_rst), 32'h6);
    tick(1); check("s1_ch_n24", 32'(ch_rst), 32'h6);
    tick(1); check("s1_ch_n25", 32'(ch_rst), 32'h4);
    tick(1); check("s1_ch_n26", 32'(ch_rst), 32'h4);
             check("s1_ready_n26", 32'(all_ready), 32'd0);
    tick(1); check("s1_ch_n27", 32'(ch_rst), 32'h0);
             check("s1_ready_n27", 32'(all_ready), 32'd1);
             check_st("s1_run_n27", ST_RUN);
    tick(3); check("s1_ch_n30", 32'(ch_rst), 32'h0);

    // ---- Lock drop in RUN, then relock --------------------------------------
    pll_lock = 1'b0;                                    // n30
    tick(2); check_st("s4_run_n32", ST_RUN);
             check("s4_ready_n32", 32'(all_ready), 32'd1);
    tick(1); check_st("s4_pllrst_n33", ST_PLL_RST);
             check("s4_ch_n33", 32'(ch_rst), 32'h7);
             check("s4_ready_n33", 32'(all_ready), 32'd0);
             check("s4_loss_n33", 32'(loss_cnt), 32'd1);
             check("s4_retry_n33", 32'(retry_cnt), 32'd0);
             check("s4_pll_rst_n33", 32'(pll_rst), 32'd1);
    pll_lock = 1'b1;
    tick(4); check_st("s4_wait_n37", ST_WAIT_LOCK);
    tick(1); check_st("s4_stable_n38", ST_STABLE);
    tick(8); check_st("s4_release_n46", ST_RELEASE);
    tick(6); check_st("s4_run_n52", ST_RUN);
             check("s4_ch_n52", 32'(ch_rst), 32'h0);
             check("s4_loss_n52", 32'(loss_cnt), 32'd1);

    // ---- soft_rst and lock loss on the same edge ----------------------------
    tick(1); pll_lock = 1'b0;                           // n53
    tick(2); check_st("s5_run_n55", ST_RUN);
             soft_rst = 1'b1;                           // both act at E56
    tick(1); soft_rst = 1'b0;                           // n56
             check_st("s5_pllrst_n56", ST_PLL_RST);
             check("s5_loss_n56", 32'(loss_cnt), 32'd1);
             check("s5_retry_n56", 32'(retry_cnt), 32'd0);
             check("s5_ch_n56", 32'(ch_rst), 32'h7);
    pll_lock = 1'b1;

    // ---- Asynchronous rst in the middle of RELEASE --------------------------
    tick(15); check_st("s6_release_n71", ST_RELEASE);
              check("s6_ch_n71", 32'(ch_rst), 32'h6);
              check("s6_loss_n71", 32'(loss_cnt), 32'd1);
    tick(1);  check("s6_ch_n72", 32'(ch_rst), 32'h6);
    #2 rst = 1'b1;
    #1;
    check_st("s6_async_state", ST_PLL_RST);
    check("s6_async_pll_rst", 32'(pll_rst), 32'd1);
    check("s6_async_ch", 32'(ch_rst), 32'h7);
    check("s6_async_ready", 32'(all_ready), 32'd0);
    check("s6_async_fail", 32'(fail), 32'd0);
    check("s6_async_retry", 32'(retry_cnt), 32'd0);
    check("s6_async_loss", 32'(loss_cnt), 32'd0);

    // ---- Single-cycle lock glitch in STABLE ---------------------------------
    pll_lock = 1'b0;
    do_reset();                                         // n0
    tick(10); pll_lock = 1'b1;                          // n10
    tick(6);  pll_lock = 1'b0;                          // n16: lock_s low for one cycle
    tick(1);  pll_lock = 1'b1;                          // n17
    tick(1);  check_st("s2_stable_n18", ST_STABLE);
    tick(1);  check_st("s2_wait_n19", ST_WAIT_LOCK);
    tick(1);  check_st("s2_stable_n20", ST_STABLE);
    tick(7);  check_st("s2_stable_n27", ST_STABLE);
    tick(1);  check_st("s2_release_n28", ST_RELEASE);

    // ---- Lock never arrives: retries, FAIL, soft_rst recovery ---------------
    pll_lock = 1'b0;
    do_reset();                                         // n0
    tick(35); check_st("s3_wait_n35", ST_WAIT_LOCK);
              check("s3_pll_rst_n35", 32'(pll_rst), 32'd0);
              check("s3_retry_n35", 32'(retry_cnt), 32'd0);
    tick(1);  check_st("s3_pllrst_n36", ST_PLL_RST);
              check("s3_pll_rst_n36", 32'(pll_rst), 32'd1);
              check("s3_retry_n36", 32'(retry_cnt), 32'd1);
    tick(4);  check_st("s3_wait_n40", ST_WAIT_LOCK);
    tick(32); check_st("s3_pllrst_n72", ST_PLL_RST);
              check("s3_retry_n72", 32'(retry_cnt), 32'd2);
    tick(35); check_st("s3_wait_n107", ST_WAIT_LOCK);
              check("s3_fail_n107", 32'(fail), 32'd0);
    tick(1);  check_st("s3_fail_state_n108", ST_FAIL);
              check("s3_fail_n108", 32'(fail), 32'd1);
              check("s3_pll_rst_n108", 32'(pll_rst), 32'd1);
              check("s3_ch_n108", 32'(ch_rst), 32'h7);
              check("s3_retry_n108", 32'(retry_cnt), 32'd2);
    tick(12); check_st("s3_fail_hold_n120", ST_FAIL);
              check("s3_pll_rst_n120", 32'(pll_rst), 32'd1);
              soft_rst = 1'b1;
    tick(1);  soft_rst = 1'b0;                          // n121
              check_st("s3_pllrst_n121", ST_PLL_RST);
              check("s3_retry_n121", 32'(retry_cnt), 32'd0);
              check("s3_fail_n121", 32'(fail), 32'd0);
    tick(3);  check("s3_pll_rst_n124", 32'(pll_rst), 32'd1);
    tick(1);  check("s3_pll_rst_n125", 32'(pll_rst), 32'd0);
              check_st("s3_wait_n125", ST_WAIT_LOCK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001: Parameter N_CH, default 5: number of downstream clock-domain resets (1..8).
REQ-002: Parameter RST_PULSE, default 16: pll_rst pulse length in clkin1 cycles (>=2).
REQ-003: Parameter LOCK_STABLE, default 1024: cycles synchronised lock must stay high before release.
REQ-004: Parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry.
REQ-005: Parameter STAGGER, default 8: cycles between successive channel reset releases (>=1).
REQ-006: Parameter MAX_RETRY, default 3: timeouts tolerated before FAIL (0..15).
REQ-007: clkin1  in  1  sole clock; all logic is in this domain.
REQ-008: rst  in  1  reset, asynchronous and active-high.
REQ-009: pll_lock  in  1  raw PLL lock, asynchronous to clkin1.
REQ-010: soft_rst  in  1  synchronous single-cycle request to restart the sequence.
REQ-011: pll_rst  out  1  active-high reset to the PLL primitive.
REQ-012: ch_rst  out  N_CH  active-high per-channel resets; bit 0 released first.
REQ-013: all_ready  out  1  high only in RUN.
REQ-014: fail  out  1  high only in FAIL.
REQ-015: retry_cnt  out  4  timeouts since the last rst/soft_rst.
REQ-016: loss_cnt  out  8  saturating count of lock losses after RELEASE entry.
REQ-017: state  out  3  current state encoding, for debug.

Function
REQ-018: pll_lock SHALL pass through a 2-flop synchroniser (lock_s); all decisions use lock_s only.
REQ-019: States SHALL be PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL, driven by one shared counter cnt sized clog2 of the largest of RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, STAGGER*N_CH, plus 1.
REQ-020: PLL_RST: pll_rst=1, ch_rst all 1; after RST_PULSE cycles go to WAIT_LOCK with cnt=0.
REQ-021: WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE with cnt=0; cnt reaching LOCK_TIMEOUT-1 with lock_s=0 -> timeout.
REQ-022: On timeout, retry_cnt==MAX_RETRY -> FAIL; otherwise retry_cnt+1 and go to PLL_RST.
REQ-023: STABLE: lock_s=0 -> WAIT_LOCK with cnt=0 (glitch restarts timeout); LOCK_STABLE consecutive lock_s=1 cycles -> RELEASE with cnt=0.
REQ-024: RELEASE: ch_rst[k] SHALL fall STAGGER*(k+1) cycles after RELEASE entry; the cycle ch_rst[N_CH-1] falls, the next state is RUN.
REQ-025: A released ch_rst bit SHALL remain 0 until lock loss, soft_rst or rst.
REQ-026: In RELEASE or RUN, lock_s=0 SHALL set all ch_rst=1 and all_ready=0 on the next clkin1 edge, increment loss_cnt (saturating at 255), go to PLL_RST, and leave retry_cnt unchanged.
REQ-027: FAIL: pll_rst=1, ch_rst all 1; only soft_rst or rst exits it.
REQ-028: soft_rst in any state SHALL go to PLL_RST with cnt=0 and retry_cnt=0, and leave loss_cnt unchanged.
REQ-029: Simultaneous events, in priority order: rst > soft_rst > lock loss > timeout > normal advance.
REQ-030: All outputs SHALL be registered; no combinational path from pll_lock or soft_rst to any output.

Reset
REQ-031: While rst=1, all of the following SHALL hold asynchronously: state=PLL_RST, cnt=0, pll_rst=1, ch_rst all 1, all_ready=0, fail=0, retry_cnt=0, loss_cnt=0, and both synchroniser flops=0.
REQ-032: After rst deasserts, the sequence SHALL start at PLL_RST cycle 0.

Structure
REQ-033: Package pll_seq_pkg SHALL hold the state encodings (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5) and the clog2 helper.
REQ-034: The synchroniser SHALL be sub-module sync_2ff, which is reusable by the other PLL wrappers; everything else is flat.

Verification (N_CH=3, RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGGER=2, MAX_RETRY=2)
REQ-035: Lock rises 10 cycles after rst release and holds -> pll_rst high for 4 cycles; ch_rst[0]/[1]/[2] fall 2/4/6 cycles after RELEASE entry; all_ready=1 afterward.
REQ-036: Lock glitches low for 1 cycle at STABLE count 5 -> returns to WAIT_LOCK; RELEASE is delayed by a full 8 stable cycles after the glitch ends.
REQ-037: Lock never asserts -> three PLL_RST pulses (retry_cnt 0,1,2), then fail=1 and pll_rst=1 held; soft_rst -> retry_cnt=0 and a new pulse.
REQ-038: Lock drops in RUN -> ch_rst=3'b111 the next cycle, loss_cnt=1, retry_cnt unchanged, full re-sequence on relock.
REQ-039: soft_rst and a lock drop in the same cycle -> PLL_RST, retry_cnt=0, loss_cnt unchanged.
REQ-040: rst asserted mid-RELEASE with ch_rst=3'b110 -> all outputs take reset values immediately, without waiting for a clkin1 edge.
